pipe_ctrl_unit: RTL

Parametrised, pipelined successor to the single-cycle main decoder for the RV32I pipeline core.
- Decodes the D-stage opcode, including lui, auipc, jalr and I-type ALU ops.
- Carries the control bundle through the ID/EX, EX/MEM and MEM/WB registers, with stall-bubble and flush support.
- Generates pcsrc_e and illegal_d, and keeps a retired-instruction counter.
- Sits between the hazard unit and the datapath pipeline registers.

---
 rtl/pipe_ctrl_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipelined RV32I main decoder: decodes the D-stage opcode and carries the
// control bundle through ID/EX, EX/MEM and MEM/WB with bubble/flush support.
module pipe_ctrl_unit #(
  parameter int IMMSRC_W = 3,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 32,
  parameter bit EXT_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode_d,
  input  logic                valid_d,
  input  logic                stall_d,
  input  logic                flush_e,
  input  logic                zero_e,
  output logic [IMMSRC_W-1:0] immsrc_d,
  output logic                illegal_d,
  output logic                regwrite_e,
  output logic                memwrite_e,
  output logic                branch_e,
  output logic                jump_e,
  output logic                jalr_e,
  output logic                alusrc_e,
  output logic                alusrca_e,
  output logic [1:0]          resultsrc_e,
  output logic [ALUOP_W-1:0]  aluop_e,
  output logic                pcsrc_e,
  output logic                regwrite_m,
  output logic                memwrite_m,
  output logic [1:0]          resultsrc_m,
  output logic                regwrite_w,
  output logic [1:0]          resultsrc_w,
  output logic [CNT_W-1:0]    instret
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic       alusrc;
    logic       alusrca;
    logic [1:0] resultsrc;
    logic [1:0] aluop;
  } ctl_t;

  ctl_t       dec;
  logic [2:0] dec_imm;
  logic       known;

  always_comb begin
    dec     = '0;
    dec_imm = 3'b000;
    known   = 1'b1;
    case (opcode_d)
      OP_R: begin
        dec.regwrite = 1'b1; dec.aluop = 2'b10;
      end
      OP_LW: begin
        dec.alusrc = 1'b1; dec.resultsrc = 2'b01; dec.regwrite = 1'b1;
      end
      OP_SW: begin
        dec.alusrc = 1'b1; dec_imm = 3'b001; dec.memwrite = 1'b1;
      end
      OP_BR: begin
        dec_imm = 3'b010; dec.branch = 1'b1; dec.aluop = 2'b01;
      end
      OP_IALU: begin
        dec.alusrc = 1'b1; dec.regwrite = 1'b1; dec.aluop = 2'b11;
      end
      OP_JAL: begin
        dec.resultsrc = 2'b10; dec_imm = 3'b011; dec.regwrite = 1'b1;
        dec.jump = 1'b1;
      end
      OP_JALR: begin
        if (EXT_EN) begin
          dec.alusrc = 1'b1; dec.resultsrc = 2'b10; dec.regwrite = 1'b1;
          dec.jump = 1'b1; dec.jalr = 1'b1;
        end else begin
          known = 1'b0;
        end
      end
      OP_LUI: begin
        if (EXT_EN) begin
          dec.resultsrc = 2'b11; dec_imm = 3'b100; dec.regwrite = 1'b1;
        end else begin
          known = 1'b0;
        end
      end
      OP_AUIPC: begin
        if (EXT_EN) begin
          dec.alusrc = 1'b1; dec.alusrca = 1'b1; dec_imm = 3'b100;
          dec.regwrite = 1'b1;
        end else begin
          known = 1'b0;
        end
      end
      default: known = 1'b0;
    endcase
  end

  assign immsrc_d  = IMMSRC_W'(dec_imm);
  assign illegal_d = valid_d & ~known;

  ctl_t       e_q;
  logic       valid_e, valid_m, valid_w;
  logic       regwrite_mq, memwrite_mq, regwrite_wq;
  logic [1:0] resultsrc_mq, resultsrc_wq;

  // Reset, stall and flush all collapse into a single bubble in E.
  always_ff @(posedge clk) begin
    if (!rst_n || stall_d || flush_e) begin
      e_q     <= '0;
      valid_e <= 1'b0;
    end else begin
      e_q     <= dec;
      valid_e <= valid_d & known;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_m      <= 1'b0;
      regwrite_mq  <= 1'b0;
      memwrite_mq  <= 1'b0;
      resultsrc_mq <= 2'b00;
      valid_w      <= 1'b0;
      regwrite_wq  <= 1'b0;
      resultsrc_wq <= 2'b00;
      instret      <= '0;
    end else begin
      valid_m      <= valid_e;
      regwrite_mq  <= regwrite_e;
      memwrite_mq  <= memwrite_e;
      resultsrc_mq <= resultsrc_e;
      valid_w      <= valid_m;
      regwrite_wq  <= regwrite_m;
      resultsrc_wq <= resultsrc_m;
      if (valid_w) instret <= instret + CNT_W'(1);
    end
  end

  assign regwrite_e  = valid_e & e_q.regwrite;
  assign memwrite_e  = valid_e & e_q.memwrite;
  assign branch_e    = valid_e & e_q.branch;
  assign jump_e      = valid_e & e_q.jump;
  assign jalr_e      = valid_e & e_q.jalr;
  assign alusrc_e    = valid_e & e_q.alusrc;
  assign alusrca_e   = valid_e & e_q.alusrca;
  assign resultsrc_e = valid_e ? e_q.resultsrc : 2'b00;
  assign aluop_e     = valid_e ? ALUOP_W'(e_q.aluop) : '0;
  assign pcsrc_e     = valid_e & ((e_q.branch & zero_e) | e_q.jump);

  assign regwrite_m  = valid_m & regwrite_mq;
  assign memwrite_m  = valid_m & memwrite_mq;
  assign resultsrc_m = valid_m ? resultsrc_mq : 2'b00;
  assign regwrite_w  = valid_w & regwrite_wq;
  assign resultsrc_w = valid_w ? resultsrc_wq : 2'b00;

endmodule
